// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers behind a pointer byte, with host-side read port.
// Define I2C_TGT_AUTOINC_EN to advance the register pointer after every data byte.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  localparam int        AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] hrd_addr,
  output logic [7:0]    hrd_data,
  output logic          wr_stb,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          rd_stb,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_q, sda_q, scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    sr;
  logic [3:0]    bit_cnt;
  logic          byte_full;
  logic [7:0]    tx_sr;
  logic          rw_q;
  logic [AW-1:0] ptr, ptr_adv;
  logic [7:0]    regs [NUM_REGS];

  logic oe_nxt, busy_nxt, cnt_clr, do_write, do_load, ptr_set, tx_shift, rw_load;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_full = (bit_cnt == 4'd8);
  assign hrd_data  = regs[hrd_addr];

`ifdef I2C_TGT_AUTOINC_EN
  assign ptr_adv = ptr + AW'(1);  // power-of-two count makes the wrap free
`else
  assign ptr_adv = ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit-level work happens on SCL edges: sample on rise, act and move SDA on fall.
  always_comb begin
    state_nxt = state;
    oe_nxt    = sda_oe;
    busy_nxt  = busy;
    cnt_clr   = 1'b0;
    do_write  = 1'b0;
    do_load   = 1'b0;
    ptr_set   = 1'b0;
    tx_shift  = 1'b0;
    rw_load   = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      oe_nxt    = 1'b0;
      cnt_clr   = 1'b1;
    end else if (scl_fall) begin
      case (state)
        ADDR: if (byte_full) begin
          if (sr[7:1] == DEV_ADDR) begin
            state_nxt = ADDR_ACK;
            oe_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            rw_load   = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
        ADDR_ACK: begin
          cnt_clr = 1'b1;
          if (rw_q) begin
            state_nxt = RDATA;
            do_load   = 1'b1;
            oe_nxt    = ~regs[ptr][7];
          end else begin
            state_nxt = PTR;
            oe_nxt    = 1'b0;
          end
        end
        PTR: if (byte_full) begin
          state_nxt = PTR_ACK;
          ptr_set   = 1'b1;
          oe_nxt    = 1'b1;
        end
        PTR_ACK, WDATA_ACK: begin
          state_nxt = WDATA;
          oe_nxt    = 1'b0;
          cnt_clr   = 1'b1;
        end
        WDATA: if (byte_full) begin
          state_nxt = WDATA_ACK;
          do_write  = 1'b1;
          oe_nxt    = 1'b1;
        end
        RDATA: begin
          if (byte_full) begin
            state_nxt = RDATA_MACK;
            oe_nxt    = 1'b0;
            cnt_clr   = 1'b1;
          end else begin
            tx_shift = 1'b1;
            oe_nxt   = ~tx_sr[6];
          end
        end
        RDATA_MACK: begin
          cnt_clr = 1'b1;
          // sr[0] holds SDA as sampled on the acknowledge clock's rising edge
          if (bit_cnt != 4'd0 && !sr[0]) begin
            state_nxt = RDATA;
            do_load   = 1'b1;
            oe_nxt    = ~regs[ptr][7];
          end else begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      sr        <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rw_q      <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
      sda_oe   <= oe_nxt;
      busy     <= busy_nxt;
      wr_stb   <= do_write;
      rd_stb   <= do_load;
      if (cnt_clr)       bit_cnt <= '0;
      else if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
      if (scl_rise) sr <= {sr[6:0], sda_s};
      if (rw_load)  rw_q <= sr[0];
      if (ptr_set)  ptr <= sr[AW-1:0];
      if (do_write) begin
        regs[ptr] <= sr;
        reg_addr  <= ptr;
        reg_wdata <= sr;
        ptr       <= ptr_adv;
      end
      if (do_load) begin
        tx_sr    <= regs[ptr];
        reg_addr <= ptr;
        ptr      <= ptr_adv;
      end else if (tx_shift) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C initiator, strobe scoreboard, directed transfers.
// Expected values follow the I2C_TGT_AUTOINC_EN setting used for the build.
module tb_i2c_target_regs;

`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  localparam int Q = 200;  // quarter SCL period in ns (20 clk cycles)

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       host_pull;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] hrd_addr;
  logic [7:0] hrd_data;
  logic       wr_stb;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       rd_stb;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];     // {reg_addr, reg_wdata} per expected wr_stb
  logic [3:0]  exp_rd_q[$];  // reg_addr per expected rd_stb

  assign sda_bus = ~(sda_oe | host_pull);

  i2c_target_regs #(.DEV_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .hrd_addr(hrd_addr), .hrd_data(hrd_data), .wr_stb(wr_stb),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .rd_stb(rd_stb), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_stb: unexpected strobe addr %0h data %0h", reg_addr, reg_wdata);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if ({reg_addr, reg_wdata} !== e) begin
            n_fail++;
            $display("FAIL wr_stb: got %0h, expected %0h", {reg_addr, reg_wdata}, e);
          end
        end
      end
      if (rd_stb) begin
        n_tests++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_stb: unexpected strobe addr %0h", reg_addr);
        end else begin
          logic [3:0] e;
          e = exp_rd_q.pop_front();
          if (reg_addr !== e) begin
            n_fail++;
            $display("FAIL rd_stb: got addr %0h, expected %0h", reg_addr, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic i2c_start();
    host_pull = 1'b0; #Q;
    scl = 1'b1;       #Q;
    host_pull = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic i2c_stop();
    host_pull = 1'b1; #Q;
    scl = 1'b1;       #Q;
    host_pull = 1'b0; #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      host_pull = ~b[i]; #Q;
      scl = 1'b1;        #(2*Q);
      scl = 1'b0;        #Q;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    host_pull = 1'b0; #Q;
    scl = 1'b1;       #Q;
    ack = ~sda_bus;   #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic read_byte(input logic ack_in, output logic [7:0] b);
    host_pull = 1'b0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1;
      #Q; b = {b[6:0], sda_bus};
      #Q; scl = 1'b0;
      #Q;
    end
    host_pull = ack_in; #Q;
    scl = 1'b1;         #(2*Q);
    scl = 1'b0;         #Q;
    host_pull = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [7:0] exp, input string name);
    hrd_addr = a; #1;
    check(name, {8'h0, hrd_data}, {8'h0, exp});
  endtask

  logic       ack;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; scl = 1'b1; host_pull = 1'b0; hrd_addr = '0;
    repeat (5) @(posedge clk);
    #3;
    check("reset sda_oe", {15'h0, sda_oe}, 16'h0);
    check("reset busy", {15'h0, busy}, 16'h0);
    check("reset strobes", {14'h0, wr_stb, rd_stb}, 16'h0);
    check("reset reg_addr/wdata", {4'h0, reg_addr, reg_wdata}, 16'h0);
    rst = 1'b0;
    #(4*Q);

    // write 0x11, 0x22 from pointer 3
    exp_q.push_back({4'h3, 8'h11});
    exp_q.push_back({AI ? 4'h4 : 4'h3, 8'h22});
    i2c_start();
    write_byte(8'hA0, ack); check("wr addr ack", {15'h0, ack}, 16'h1);
    check("wr busy", {15'h0, busy}, 16'h1);
    write_byte(8'h03, ack); check("wr ptr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h11, ack); check("wr d0 ack", {15'h0, ack}, 16'h1);
    write_byte(8'h22, ack); check("wr d1 ack", {15'h0, ack}, 16'h1);
    i2c_stop();
    check("wr busy after P", {15'h0, busy}, 16'h0);
    read_reg(4'h4, AI ? 8'h22 : 8'h00, "wr reg4");
    read_reg(4'h3, AI ? 8'h11 : 8'h22, "wr reg3");

    // random read from pointer 3 via repeated START
    exp_rd_q.push_back(4'h3);
    exp_rd_q.push_back(AI ? 4'h4 : 4'h3);
    i2c_start();
    write_byte(8'hA0, ack); check("rd addr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h03, ack); check("rd ptr ack", {15'h0, ack}, 16'h1);
    i2c_start();
    write_byte(8'hA1, ack); check("rd raddr ack", {15'h0, ack}, 16'h1);
    read_byte(1'b1, rb); check("rd byte0", {8'h0, rb}, {8'h0, AI ? 8'h11 : 8'h22});
    read_byte(1'b0, rb); check("rd byte1", {8'h0, rb}, 16'h0022);
    check("rd busy after NACK", {15'h0, busy}, 16'h1);
    check("rd sda released", {15'h0, sda_oe}, 16'h0);
    i2c_stop();
    check("rd busy after P", {15'h0, busy}, 16'h0);

    // wrong address
    i2c_start();
    write_byte(8'hA2, ack); check("wa addr nack", {15'h0, ack}, 16'h0);
    check("wa busy", {15'h0, busy}, 16'h0);
    write_byte(8'h05, ack); check("wa ptr nack", {15'h0, ack}, 16'h0);
    check("wa busy2", {15'h0, busy}, 16'h0);
    i2c_stop();

    // pointer wrap
    exp_q.push_back({4'hF, 8'hAA});
    exp_q.push_back({AI ? 4'h0 : 4'hF, 8'hBB});
    i2c_start();
    write_byte(8'hA0, ack); check("wrap addr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h0F, ack); check("wrap ptr ack", {15'h0, ack}, 16'h1);
    write_byte(8'hAA, ack); check("wrap d0 ack", {15'h0, ack}, 16'h1);
    write_byte(8'hBB, ack); check("wrap d1 ack", {15'h0, ack}, 16'h1);
    i2c_stop();
    read_reg(4'hF, AI ? 8'hAA : 8'hBB, "wrap reg15");
    read_reg(4'h0, AI ? 8'hBB : 8'h00, "wrap reg0");

    // abort: STOP after 4 data bits, then reset mid-read
    i2c_start();
    write_byte(8'hA0, ack); check("ab addr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h03, ack); check("ab ptr ack", {15'h0, ack}, 16'h1);
    send_bits(8'hF0, 4);
    i2c_stop();
    check("ab busy after P", {15'h0, busy}, 16'h0);
    read_reg(4'h3, AI ? 8'h11 : 8'h22, "ab reg3 kept");
    exp_rd_q.push_back(4'h3);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hA1, ack); check("ab raddr ack", {15'h0, ack}, 16'h1);
    check("ab sda driving bit7", {15'h0, sda_oe}, 16'h1);
    #(Q/2);
    rst = 1'b1; #1;
    check("ab rst sda_oe", {15'h0, sda_oe}, 16'h0);
    check("ab rst busy", {15'h0, busy}, 16'h0);
    check("ab rst outs", {2'b0, wr_stb, rd_stb, reg_addr, reg_wdata}, 16'h0);
    for (int i = 0; i < 16; i++) read_reg(4'(i), 8'h00, "ab rst reg");
    host_pull = 1'b0; scl = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #(4*Q);

    // fresh START after reset
    exp_q.push_back({4'h1, 8'h5A});
    i2c_start();
    write_byte(8'hA0, ack); check("post addr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h01, ack); check("post ptr ack", {15'h0, ack}, 16'h1);
    write_byte(8'h5A, ack); check("post d0 ack", {15'h0, ack}, 16'h1);
    i2c_stop();
    read_reg(4'h1, 8'h5A, "post reg1");
    #(2*Q);

    check("wr queue drained", 16'(exp_q.size()), 16'h0);
    check("rd queue drained", 16'(exp_rd_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
